rx_crc_frame_ctrl: RTL and testbench
====================================

RX_CRC_FRAME_CTRL -- requirements
Module: rx_crc_frame_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CRC_POLY, 8'h07, CRC-8 generator polynomial (x^8+x^2+x+1)
- CRC_INIT, 8'h00, CRC register seed per frame
- CNT_W, 8, width of the frame statistics counters
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  frame acceptance enable
- rx_ready  in  1  frame-complete flag from the UART receiver
- rx_data  in  8  received data byte, valid while rx_ready=1
- rx_crc  in  8  received CRC byte, valid while rx_ready=1
- clear_cnt  in  1  synchronous clear of statistics counters
- out_ready  in  1  consumer ready
- out_valid  out  1  checked byte available
- out_data  out  8  checked byte
- crc_err  out  1  one-cycle pulse: CRC mismatch, frame dropped
- overrun  out  1  one-cycle pulse: frame arrived while busy, dropped
- busy  out  1  high whenever state != IDLE
- good_cnt  out  CNT_W  frames delivered to consumer
- err_cnt  out  CNT_W  CRC-failed frames

Function
REQ-003 A frame event SHALL be a rising edge of rx_ready (rx_ready=1 and registered previous value rx_ready_d=0).
REQ-004 The FSM SHALL have states IDLE, CALC, CHECK and HOLD.
REQ-005 In IDLE with enable=1 and a frame event, the block SHALL latch rx_data and rx_crc, load the CRC register with CRC_INIT, clear the bit index and enter CALC on the same edge.
REQ-006 In IDLE with enable=0, frame events SHALL be ignored: no capture, no overrun, no counter change.
REQ-007 CALC SHALL run exactly 8 cycles, MSB first: fb = crc[7] ^ data[7-i]; crc <= {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 8'h00). After bit 7 it SHALL enter CHECK.
REQ-008 CHECK SHALL last one cycle. If the computed CRC equals the latched rx_crc, the block SHALL drive out_data with the latched byte, set out_valid and enter HOLD. Otherwise it SHALL pulse crc_err for one cycle, increment err_cnt and return to IDLE.
REQ-009 out_valid SHALL rise exactly 9 clock edges after the edge that captured the frame event.
REQ-010 In HOLD, out_valid and out_data SHALL stay stable until out_valid&&out_ready is sampled. On that edge the block SHALL deassert out_valid, increment good_cnt and enter IDLE.
REQ-011 A frame event sampled in CALC, CHECK or HOLD SHALL pulse overrun for one cycle and SHALL be dropped, without altering the frame in progress. This includes the HOLD edge on which the handshake completes.
REQ-012 good_cnt and err_cnt SHALL saturate at all-ones and SHALL not wrap.
REQ-013 clear_cnt=1 SHALL zero both counters on that edge. If clear_cnt coincides with an increment, the clear SHALL win.
REQ-014 busy SHALL be combinational from state (state != IDLE).
REQ-015 Changing enable outside IDLE SHALL NOT affect the frame in progress.

Reset
REQ-016 On reset=1 at a clock edge, the block SHALL force state=IDLE, out_valid=0, out_data=0, crc_err=0, overrun=0, good_cnt=0, err_cnt=0, CRC register=CRC_INIT and bit index=0. This applies in any state, including mid-CALC and in HOLD.
REQ-017 reset SHALL set rx_ready_d to 1, so an rx_ready level held high across reset release is not treated as a frame event.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Good frame: rx_data=8'h01, rx_crc=8'h07, out_ready=1 -> out_valid 9 edges after capture, out_data=8'h01, good_cnt=1, crc_err never asserted.
- Bad CRC: rx_data=8'hFF, rx_crc=8'h00 (correct value 8'hF3) -> one crc_err pulse, err_cnt=1, out_valid stays 0, return to IDLE.
- Backpressure/overrun: rx_data=8'h00, rx_crc=8'h00, out_ready=0; second rx_ready rise during HOLD -> overrun pulse, out_data stays 8'h00 until out_ready=1, good_cnt=1.
- Enable low: enable=0, valid frame -> no output, no pulses, counters unchanged, busy=0.
- Reset mid-CALC, with rx_ready held high across reset -> all outputs zero, IDLE, no capture until rx_ready falls then rises.
- Saturation/clear: CNT_W=2, 4 bad frames -> err_cnt=3; clear_cnt pulsed on the edge of a 5th crc_err -> err_cnt=0.

Source files
------------

// File: rtl/rx_crc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx_crc_frame_ctrl
//
// Accepts one byte plus its CRC-8 from a UART receiver on each rising edge
// of rx_ready, recomputes the CRC bit-serially (MSB first, 8 cycles), and
// either hands the byte to a consumer through a valid/ready hold stage or
// drops it with a crc_err pulse. Frames that arrive while a frame is still
// being processed are dropped and flagged with an overrun pulse. Good and
// CRC-failed frames are counted in saturating statistics counters.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   enable     frame acceptance enable (only looked at in IDLE)
//   rx_ready   frame-complete flag; its rising edge is the frame event
//   rx_data    received byte, valid while rx_ready=1
//   rx_crc     received CRC byte, valid while rx_ready=1
//   clear_cnt  synchronous clear of both statistics counters
//   out_ready  consumer ready
//   out_valid  checked byte available (held until accepted)
//   out_data   checked byte
//   crc_err    one-cycle pulse: CRC mismatch, frame dropped
//   overrun    one-cycle pulse: frame arrived while busy, dropped
//   busy       state != IDLE
//   good_cnt   frames delivered to the consumer (saturating)
//   err_cnt    CRC-failed frames (saturating)
// ---------------------------------------------------------------------------
module rx_crc_frame_ctrl #(
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    input  logic [7:0]       rx_crc,
    input  logic             clear_cnt,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             crc_err,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q,        state_d;
    logic             rx_ready_prev_q, rx_ready_prev_d;
    logic [7:0]       data_q,         data_d;
    logic [7:0]       crc_ref_q,      crc_ref_d;
    logic [7:0]       crc_q,          crc_d;
    logic [2:0]       bit_idx_q,      bit_idx_d;
    logic             out_valid_q,    out_valid_d;
    logic [7:0]       out_data_q,     out_data_d;
    logic             crc_err_q,      crc_err_d;
    logic             overrun_q,      overrun_d;
    logic [CNT_W-1:0] good_cnt_q,     good_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,      err_cnt_d;

    logic             frame_evt_s;
    logic             good_inc_s;
    logic             err_inc_s;

    // One serial CRC-8 step: shift left, fold the polynomial in when the
    // outgoing MSB differs from the incoming data bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic din);
        logic fb;
        fb        = crc_in[7] ^ din;
        crc8_step = {crc_in[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    // Saturating increment: all-ones sticks instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Frame event is the rising edge of rx_ready.
    assign frame_evt_s = rx_ready & ~rx_ready_prev_q;

    // Next-state, datapath and pulse generation.
    always_comb begin
        state_d         = state_q;
        rx_ready_prev_d = rx_ready;
        data_d          = data_q;
        crc_ref_d       = crc_ref_q;
        crc_d           = crc_q;
        bit_idx_d       = bit_idx_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        crc_err_d       = 1'b0;
        overrun_d       = 1'b0;
        good_inc_s      = 1'b0;
        err_inc_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && frame_evt_s) begin
                    data_d    = rx_data;
                    crc_ref_d = rx_crc;
                    crc_d     = CRC_INIT;
                    bit_idx_d = 3'd0;
                    state_d   = CALC;
                end else begin
                    state_d   = IDLE;
                end
            end
            CALC: begin
                crc_d     = crc8_step(crc_q, data_q[3'd7 - bit_idx_q]);
                // The index wraps back to 0 after bit 7, ready for the next frame.
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    state_d = CHECK;
                end else begin
                    state_d = CALC;
                end
            end
            CHECK: begin
                if (crc_q == crc_ref_q) begin
                    out_data_d  = data_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    crc_err_d   = 1'b1;
                    err_inc_s   = 1'b1;
                    state_d     = IDLE;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    good_inc_s  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d     = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any frame event outside IDLE is dropped, including the HOLD
        // handshake edge; the frame in progress is untouched.
        if (frame_evt_s && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = 1'b0;
        end

        // Clear has priority over a coincident increment.
        if (clear_cnt) begin
            good_cnt_d = '0;
        end else if (good_inc_s) begin
            good_cnt_d = sat_inc(good_cnt_q);
        end else begin
            good_cnt_d = good_cnt_q;
        end

        if (clear_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc_s) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and datapath registers with synchronous reset. rx_ready_prev
    // resets high so a level held across reset release is not an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rx_ready_prev_q <= 1'b1;
            data_q          <= 8'h00;
            crc_ref_q       <= 8'h00;
            crc_q           <= CRC_INIT;
            bit_idx_q       <= 3'd0;
            out_valid_q     <= 1'b0;
            out_data_q      <= 8'h00;
            crc_err_q       <= 1'b0;
            overrun_q       <= 1'b0;
            good_cnt_q      <= '0;
            err_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            rx_ready_prev_q <= rx_ready_prev_d;
            data_q          <= data_d;
            crc_ref_q       <= crc_ref_d;
            crc_q           <= crc_d;
            bit_idx_q       <= bit_idx_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            crc_err_q       <= crc_err_d;
            overrun_q       <= overrun_d;
            good_cnt_q      <= good_cnt_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign crc_err   = crc_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
    assign good_cnt  = good_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rx_crc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for rx_crc_frame_ctrl. Two instances share all inputs:
// dut_a uses the default 8-bit counters, dut_b uses 2-bit counters so that
// saturation is reachable. Inputs change on the falling edge, outputs are
// sampled on the falling edge. Expected output bytes are pushed to a queue
// when a frame with a correct CRC is driven and popped on each handshake.
// ---------------------------------------------------------------------------
module tb_rx_crc_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic [7:0] rx_crc;
    logic       clear_cnt;
    logic       out_ready;

    logic       out_valid_a, crc_err_a, overrun_a, busy_a;
    logic [7:0] out_data_a, good_cnt_a, err_cnt_a;
    logic       out_valid_b, crc_err_b, overrun_b, busy_b;
    logic [7:0] out_data_b;
    logic [1:0] good_cnt_b, err_cnt_b;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         exp_good = 0;
    int         exp_err  = 0;
    int         crc_err_seen = 0;
    int         overrun_seen = 0;

    always #5 clk = ~clk;

    rx_crc_frame_ctrl #(.CRC_POLY(8'h07), .CRC_INIT(8'h00), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_crc(rx_crc), .clear_cnt(clear_cnt),
        .out_ready(out_ready), .out_valid(out_valid_a), .out_data(out_data_a),
        .crc_err(crc_err_a), .overrun(overrun_a), .busy(busy_a),
        .good_cnt(good_cnt_a), .err_cnt(err_cnt_a)
    );

    rx_crc_frame_ctrl #(.CRC_POLY(8'h07), .CRC_INIT(8'h00), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_crc(rx_crc), .clear_cnt(clear_cnt),
        .out_ready(out_ready), .out_valid(out_valid_b), .out_data(out_data_b),
        .crc_err(crc_err_b), .overrun(overrun_b), .busy(busy_b),
        .good_cnt(good_cnt_b), .err_cnt(err_cnt_b)
    );

    // Reference CRC-8: byte-wise formulation (xor the byte in, then 8 shifts).
    function automatic logic [7:0] model_crc(input logic [7:0] d);
        logic [7:0] c;
        c = 8'h00 ^ d;
        for (int k = 0; k < 8; k++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (crc_err_a) crc_err_seen++;
        if (overrun_a) overrun_seen++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] c);
        rx_data  = d;
        rx_crc   = c;
        rx_ready = 1'b1;
        if (enable && (model_crc(d) == c)) exp_q.push_back(d);
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (!out_valid_a && lat < budget) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset = 1'b1; enable = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
        rx_crc = 8'h00; clear_cnt = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid_a); end
        n_cmp++; if (out_data_a !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %h want 00", out_data_a); end
        n_cmp++; if ({crc_err_a, overrun_a, busy_a} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {crc_err_a, overrun_a, busy_a}); end
        n_cmp++; if ({good_cnt_a, err_cnt_a} !== 16'h0000) begin n_bad++; $display("FAIL rst_cnt: got %h want 0000", {good_cnt_a, err_cnt_a}); end
        e = {out_valid_b, crc_err_b, overrun_b, busy_b, good_cnt_b, err_cnt_b};
        n_cmp++; if (e !== 8'h00 || out_data_b !== 8'h00) begin n_bad++; $display("FAIL rst_dut_b: got %h/%h want 00/00", e, out_data_b); end
        reset = 1'b0;
        exp_good = 0; exp_err = 0; exp_q.delete();
        tick();
    endtask

    task automatic test_good_frame();
        int lat;
        logic [7:0] e;
        out_ready = 1'b1; crc_err_seen = 0;
        send_frame(8'h01, 8'h07);
        enable = 1'b0;                // must not disturb the frame in progress
        wait_valid(20, lat);
        enable = 1'b1;
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL good_latency: got %0d want 9", lat); end
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL good_pop: got %h with empty scoreboard", out_data_a);
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (out_data_a !== e || out_data_b !== e) begin n_bad++; $display("FAIL good_data: got %h/%h want %h", out_data_a, out_data_b, e); end
        end
        tick();
        exp_good++;
        n_cmp++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin n_bad++; $display("FAIL good_release: got valid=%b busy=%b want 0/0", out_valid_a, busy_a); end
        n_cmp++; if (good_cnt_a !== 8'(exp_good)) begin n_bad++; $display("FAIL good_cnt: got %0d want %0d", good_cnt_a, exp_good); end
        n_cmp++; if (crc_err_seen !== 0) begin n_bad++; $display("FAIL good_no_crc_err: got %0d pulses want 0", crc_err_seen); end
    endtask

    task automatic test_bad_crc();
        int ov_seen;
        out_ready = 1'b1; crc_err_seen = 0; ov_seen = 0;
        send_frame(8'hFF, 8'h00);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid_a) ov_seen++;
        end
        exp_err++;
        n_cmp++; if (crc_err_seen !== 1) begin n_bad++; $display("FAIL bad_pulses: got %0d want 1", crc_err_seen); end
        n_cmp++; if (ov_seen !== 0) begin n_bad++; $display("FAIL bad_out_valid: got %0d cycles want 0", ov_seen); end
        n_cmp++; if (err_cnt_a !== 8'(exp_err) || busy_a !== 1'b0) begin n_bad++; $display("FAIL bad_err_cnt: got %0d busy=%b want %0d busy=0", err_cnt_a, busy_a, exp_err); end
    endtask

    task automatic test_backpressure();
        int lat;
        int stable_bad;
        logic [7:0] e;
        out_ready = 1'b0; overrun_seen = 0; stable_bad = 0;
        send_frame(8'h00, 8'h00);
        wait_valid(20, lat);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL bp_latency: got %0d want 9", lat); end
        rx_data = 8'hAA; rx_crc = 8'h5C; rx_ready = 1'b1;
        tick();
        n_cmp++; if (overrun_a !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %b want 1", overrun_a); end
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid_a !== 1'b1 || out_data_a !== 8'h00) stable_bad++;
        end
        n_cmp++; if (overrun_seen !== 1) begin n_bad++; $display("FAIL bp_overrun_width: got %0d pulses want 1", overrun_seen); end
        n_cmp++; if (stable_bad !== 0) begin n_bad++; $display("FAIL bp_hold_stable: got %0d bad cycles want 0", stable_bad); end
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL bp_pop: got %h with empty scoreboard", out_data_a);
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (out_data_a !== e || out_data_b !== e) begin n_bad++; $display("FAIL bp_data: got %h/%h want %h", out_data_a, out_data_b, e); end
        end
        tick();
        exp_good++;
        n_cmp++; if (out_valid_a !== 1'b0 || good_cnt_a !== 8'(exp_good)) begin n_bad++; $display("FAIL bp_release: got valid=%b cnt=%0d want 0/%0d", out_valid_a, good_cnt_a, exp_good); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] e;
        out_ready = 1'b0; overrun_seen = 0;
        send_frame(8'h5A, model_crc(8'h5A));
        wait_valid(20, lat);
        // Handshake edge coincides with a new frame event: dropped + overrun.
        out_ready = 1'b1; rx_data = 8'h33; rx_crc = 8'h00; rx_ready = 1'b1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL b2b_pop1: got %h with empty scoreboard", out_data_a);
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (out_data_a !== e || out_valid_a !== 1'b1) begin n_bad++; $display("FAIL b2b_data1: got %h valid=%b want %h valid=1", out_data_a, out_valid_a, e); end
        end
        tick();
        exp_good++;
        n_cmp++; if (overrun_a !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0) begin n_bad++; $display("FAIL b2b_hs_overrun: got ovr=%b valid=%b busy=%b want 1/0/0", overrun_a, out_valid_a, busy_a); end
        rx_ready = 1'b0;
        tick();
        send_frame(8'hC3, model_crc(8'hC3));
        wait_valid(20, lat);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 9", lat); end
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL b2b_pop2: got %h with empty scoreboard", out_data_a);
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (out_data_a !== e || out_data_b !== e) begin n_bad++; $display("FAIL b2b_data2: got %h/%h want %h", out_data_a, out_data_b, e); end
        end
        tick();
        exp_good++;
        n_cmp++; if (good_cnt_a !== 8'(exp_good)) begin n_bad++; $display("FAIL b2b_good_cnt: got %0d want %0d", good_cnt_a, exp_good); end
    endtask

    task automatic test_enable_low();
        int busy_seen;
        int ov_seen;
        enable = 1'b0; out_ready = 1'b1;
        crc_err_seen = 0; overrun_seen = 0; busy_seen = 0; ov_seen = 0;
        send_frame(8'h01, 8'h07);
        if (busy_a) busy_seen++;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy_a) busy_seen++;
            if (out_valid_a) ov_seen++;
        end
        enable = 1'b1;
        n_cmp++; if (busy_seen !== 0 || ov_seen !== 0) begin n_bad++; $display("FAIL en_low_idle: got busy=%0d valid=%0d want 0/0", busy_seen, ov_seen); end
        n_cmp++; if (crc_err_seen + overrun_seen !== 0) begin n_bad++; $display("FAIL en_low_pulses: got %0d want 0", crc_err_seen + overrun_seen); end
        n_cmp++; if (good_cnt_a !== 8'(exp_good) || err_cnt_a !== 8'(exp_err)) begin n_bad++; $display("FAIL en_low_cnt: got %0d/%0d want %0d/%0d", good_cnt_a, err_cnt_a, exp_good, exp_err); end
    endtask

    task automatic test_reset_mid_calc();
        int busy_seen;
        int lat;
        logic [7:0] e;
        out_ready = 1'b1; busy_seen = 0;
        rx_data = 8'h01; rx_crc = 8'h07; rx_ready = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL rmc_busy: got %b want 1", busy_a); end
        reset = 1'b1;
        tick();
        n_cmp++; if ({out_valid_a, crc_err_a, overrun_a, busy_a} !== 4'b0000 || out_data_a !== 8'h00) begin n_bad++; $display("FAIL rmc_outputs: got %b data=%h want 0000 data=00", {out_valid_a, crc_err_a, overrun_a, busy_a}, out_data_a); end
        n_cmp++; if (good_cnt_a !== 8'h00 || err_cnt_a !== 8'h00) begin n_bad++; $display("FAIL rmc_cnt: got %0d/%0d want 0/0", good_cnt_a, err_cnt_a); end
        reset = 1'b0; exp_good = 0; exp_err = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy_a) busy_seen++;
        end
        rx_ready = 1'b0;
        tick();
        if (busy_a) busy_seen++;
        n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL rmc_no_capture: got %0d busy cycles want 0", busy_seen); end
        send_frame(8'h01, 8'h07);
        wait_valid(20, lat);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL rmc_latency: got %0d want 9", lat); end
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL rmc_pop: got %h with empty scoreboard", out_data_a);
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (out_data_a !== e) begin n_bad++; $display("FAIL rmc_data: got %h want %h", out_data_a, e); end
        end
        tick();
        exp_good++;
        n_cmp++; if (good_cnt_a !== 8'(exp_good)) begin n_bad++; $display("FAIL rmc_good_cnt: got %0d want %0d", good_cnt_a, exp_good); end
    endtask

    task automatic test_saturation();
        reset = 1'b1; tick(); reset = 1'b0;
        exp_good = 0; exp_err = 0; exp_q.delete();
        out_ready = 1'b1;
        tick();
        for (int f = 0; f < 4; f++) begin
            crc_err_seen = 0;
            send_frame(8'hFF, 8'h00);
            for (int i = 0; i < 10; i++) tick();
            exp_err++;
            n_cmp++; if (crc_err_seen !== 1) begin n_bad++; $display("FAIL sat_pulse%0d: got %0d want 1", f, crc_err_seen); end
        end
        n_cmp++; if (err_cnt_b !== 2'(sat3(exp_err))) begin n_bad++; $display("FAIL sat_err_cnt_b: got %0d want %0d", err_cnt_b, sat3(exp_err)); end
        n_cmp++; if (err_cnt_a !== 8'(exp_err)) begin n_bad++; $display("FAIL sat_err_cnt_a: got %0d want %0d", err_cnt_a, exp_err); end
        send_frame(8'hFF, 8'h00);
        for (int i = 0; i < 8; i++) tick();
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        exp_err = 0;
        n_cmp++; if (crc_err_a !== 1'b1 || crc_err_b !== 1'b1) begin n_bad++; $display("FAIL clr_crc_err: got %b/%b want 1/1", crc_err_a, crc_err_b); end
        n_cmp++; if (err_cnt_a !== 8'(exp_err) || err_cnt_b !== 2'(exp_err)) begin n_bad++; $display("FAIL clr_wins: got %0d/%0d want 0/0", err_cnt_a, err_cnt_b); end
        tick();
        n_cmp++; if (crc_err_a !== 1'b0 || overrun_b !== 1'b0) begin n_bad++; $display("FAIL clr_pulse_end: got %b/%b want 0/0", crc_err_a, overrun_b); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_backpressure();
        test_back_to_back();
        test_enable_low();
        test_reset_mid_calc();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
